// File: rtl/mem_stage_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and memory (slave).
interface mem_stage_unit_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: issues load/store transactions on a variable-latency data memory,
// stalls upstream while one is outstanding, and registers the MEM/WB outputs.
module mem_stage_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             em_valid,
    input  logic             em_mem_read,
    input  logic             em_mem_write,
    input  logic [31:0]      em_alu_result,
    input  logic [31:0]      em_store_data,
    input  logic [2:0]       em_funct3,
    input  logic [4:0]       em_rd,
    input  logic             em_reg_write,
    input  logic             em_memtoreg,
    input  logic             em_jump,
    input  logic             em_pcr,
    input  logic             em_branch,
    input  logic             em_zero,
    input  logic [8:0]       em_pc_next,
    input  logic [31:0]      em_new_add,
    output logic             stall,
    mem_stage_unit_if.master dm,
    output logic             wb_valid,
    output logic [31:0]      wb_read_data,
    output logic [31:0]      wb_alu_result,
    output logic [31:0]      wb_new_add,
    output logic [4:0]       wb_rd,
    output logic [8:0]       wb_pc_next,
    output logic             wb_reg_write,
    output logic             wb_memtoreg,
    output logic             wb_jump,
    output logic             wb_pcr,
    output logic             wb_branch,
    output logic             wb_bresult,
    output logic             align_err,
    output logic             timeout_err
);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, next_state;

    logic        mem_op, legal, issue, reject, at_limit;
    logic        retire_pass, retire_mem;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] busy_cnt;
    logic [1:0]  cap_off;
    logic [2:0]  cap_funct3;
    logic [31:0] load_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        legal = 1'b0;
        case (em_funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~em_alu_result[0];
            3'b010:         legal = (em_alu_result[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
    end

    assign mem_op   = em_valid & (em_mem_read | em_mem_write);
    assign issue    = mem_op & legal;
    assign reject   = mem_op & ~legal;
    assign at_limit = (TIMEOUT_CYCLES != 0) && (busy_cnt == TIMEOUT_CYCLES - 1);

    // An ack arriving in the limit cycle takes priority over the abort.
    always_comb begin
        next_state  = state;
        stall       = 1'b0;
        retire_pass = 1'b0;
        retire_mem  = 1'b0;
        case (state)
            IDLE: begin
                retire_pass = ~issue;
                if (issue) begin
                    stall      = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (dm.dm_ack || at_limit) begin
                    retire_mem = 1'b1;
                    next_state = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        if (!rst_n) stall = 1'b0;
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = em_store_data;
        case (em_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << em_alu_result[1:0];
                wdata_d = {4{em_store_data[7:0]}};
            end
            2'b01: begin
                be_d    = em_alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{em_store_data[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = em_store_data;
            end
        endcase
    end

    always_comb begin
        lane_b    = dm.dm_rdata[{cap_off, 3'b000} +: 8];
        lane_h    = cap_off[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        load_data = dm.dm_rdata;
        case (cap_funct3)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_data = {24'd0, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_data = {16'd0, lane_h};
            default: load_data = dm.dm_rdata;
        endcase
    end

    assign dm.dm_req = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Request fields are latched once at issue so they stay stable for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= 32'd0;
            dm.dm_wdata <= 32'd0;
            dm.dm_be    <= 4'd0;
            cap_off     <= 2'd0;
            cap_funct3  <= 3'd0;
        end else if (state == IDLE && issue) begin
            dm.dm_we    <= em_mem_write;
            dm.dm_addr  <= {em_alu_result[31:2], 2'b00};
            dm.dm_wdata <= em_mem_write ? wdata_d : 32'd0;
            dm.dm_be    <= em_mem_write ? be_d : 4'b0000;
            cap_off     <= em_alu_result[1:0];
            cap_funct3  <= em_funct3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        busy_cnt <= 32'd0;
        else if (state == IDLE)            busy_cnt <= 32'd0;
        else if (!dm.dm_ack && !at_limit)  busy_cnt <= busy_cnt + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_read_data <= 32'd0;
            align_err    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            wb_valid     <= retire_mem | (retire_pass & em_valid);
            wb_reg_write <= retire_mem ? (dm.dm_ack & em_reg_write)
                                       : (retire_pass & em_valid & em_reg_write & ~reject);
            wb_read_data <= (retire_mem && dm.dm_ack && !dm.dm_we) ? load_data : 32'd0;
            align_err    <= retire_pass & reject;
            timeout_err  <= retire_mem & ~dm.dm_ack;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rd         <= 5'd0;
            wb_alu_result <= 32'd0;
            wb_new_add    <= 32'd0;
            wb_pc_next    <= 9'd0;
            wb_memtoreg   <= 1'b0;
            wb_jump       <= 1'b0;
            wb_pcr        <= 1'b0;
            wb_branch     <= 1'b0;
            wb_bresult    <= 1'b0;
        end else if (retire_pass || retire_mem) begin
            wb_rd         <= em_rd;
            wb_alu_result <= em_alu_result;
            wb_new_add    <= em_new_add;
            wb_pc_next    <= em_pc_next;
            wb_memtoreg   <= em_memtoreg;
            wb_jump       <= em_jump;
            wb_pcr        <= em_pcr;
            wb_branch     <= em_branch;
            wb_bresult    <= em_branch & em_zero;
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Testbench for mem_stage_unit: vector table of load/store/ALU ops plus hand-written
// timeout and reset sequences, with a scoreboard checking every MEM/WB retirement.
module tb_mem_stage_unit;

    logic        clk;
    logic        rst_n;
    logic        em_valid, em_mem_read, em_mem_write;
    logic [31:0] em_alu_result, em_store_data, em_new_add;
    logic [2:0]  em_funct3;
    logic [4:0]  em_rd;
    logic        em_reg_write, em_memtoreg, em_jump, em_pcr, em_branch, em_zero;
    logic [8:0]  em_pc_next;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_read_data, wb_alu_result, wb_new_add;
    logic [4:0]  wb_rd;
    logic [8:0]  wb_pc_next;
    logic        wb_reg_write, wb_memtoreg, wb_jump, wb_pcr, wb_branch, wb_bresult;
    logic        align_err, timeout_err;

    mem_stage_unit_if dmif();

    mem_stage_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .em_valid(em_valid), .em_mem_read(em_mem_read), .em_mem_write(em_mem_write),
        .em_alu_result(em_alu_result), .em_store_data(em_store_data), .em_funct3(em_funct3),
        .em_rd(em_rd), .em_reg_write(em_reg_write), .em_memtoreg(em_memtoreg),
        .em_jump(em_jump), .em_pcr(em_pcr), .em_branch(em_branch), .em_zero(em_zero),
        .em_pc_next(em_pc_next), .em_new_add(em_new_add),
        .stall(stall), .dm(dmif),
        .wb_valid(wb_valid), .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
        .wb_new_add(wb_new_add), .wb_rd(wb_rd), .wb_pc_next(wb_pc_next),
        .wb_reg_write(wb_reg_write), .wb_memtoreg(wb_memtoreg), .wb_jump(wb_jump),
        .wb_pcr(wb_pcr), .wb_branch(wb_branch), .wb_bresult(wb_bresult),
        .align_err(align_err), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          lat;
        logic        regw;
        logic        br;
        logic        zero;
        logic [31:0] exp_rdata;
        logic        exp_regw;
        logic        exp_align;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] read_data;
        logic        regw;
        logic        align;
        logic        tmo;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        bres;
    } exp_t;

    vec_t vecs[14];
    exp_t exp_q[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    endtask

    task automatic driveInputs(input vec_t v, input int idx);
        em_valid      = 1'b1;
        em_mem_read   = v.rd;
        em_mem_write  = v.wr;
        em_alu_result = v.addr;
        em_store_data = v.sdata;
        em_funct3     = v.f3;
        em_rd         = idx[4:0];
        em_reg_write  = v.regw;
        em_memtoreg   = v.rd;
        em_jump       = 1'b0;
        em_pcr        = 1'b0;
        em_branch     = v.br;
        em_zero       = v.zero;
        em_pc_next    = 9'(idx * 4);
        em_new_add    = 32'h1000 + idx;
    endtask

    // Called just after a rising edge; leaves inputs idle just after the retirement edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        int   stall_cnt;
        driveInputs(v, idx);
        e.read_data = v.exp_rdata;
        e.regw      = v.exp_regw;
        e.align     = v.exp_align;
        e.tmo       = 1'b0;
        e.rd        = idx[4:0];
        e.alu       = v.addr;
        e.bres      = v.br & v.zero;
        exp_q.push_back(e);
        #1;
        if (v.lat > 0) begin
            stall_cnt = stall ? 1 : 0;
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d dm_req", idx), 32'(dmif.dm_req), 1);
            checkOutput($sformatf("v%0d dm_addr", idx), dmif.dm_addr, v.addr & 32'hFFFF_FFFC);
            checkOutput($sformatf("v%0d dm_we", idx), 32'(dmif.dm_we), 32'(v.wr));
            checkOutput($sformatf("v%0d dm_be", idx), 32'(dmif.dm_be), 32'(v.exp_be));
            if (v.wr) checkOutput($sformatf("v%0d dm_wdata", idx), dmif.dm_wdata, v.exp_wdata);
            for (int k = 1; k <= v.lat; k++) begin
                if (k == v.lat) begin
                    dmif.dm_ack   = 1'b1;
                    dmif.dm_rdata = v.rdata;
                end
                #1;
                if (stall) stall_cnt++;
                @(posedge clk); #1;
            end
            dmif.dm_ack   = 1'b0;
            dmif.dm_rdata = 32'd0;
            em_valid      = 1'b0;
            checkOutput($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'(v.lat));
        end else begin
            checkOutput($sformatf("v%0d stall", idx), 32'(stall), 0);
            checkOutput($sformatf("v%0d no_req", idx), 32'(dmif.dm_req), 0);
            @(posedge clk); #1;
            em_valid = 1'b0;
            checkOutput($sformatf("v%0d wb_valid_1cyc", idx), 32'(wb_valid), 1);
        end
    endtask

    // Scoreboard: every retirement must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("wb_unexpected", 32'(wb_valid), 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("wb_read_data", wb_read_data, mon_e.read_data);
                checkOutput("wb_reg_write", 32'(wb_reg_write), 32'(mon_e.regw));
                checkOutput("align_err", 32'(align_err), 32'(mon_e.align));
                checkOutput("timeout_err", 32'(timeout_err), 32'(mon_e.tmo));
                checkOutput("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
                checkOutput("wb_alu_result", wb_alu_result, mon_e.alu);
                checkOutput("wb_bresult", 32'(wb_bresult), 32'(mon_e.bres));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        int   req_cycles;
        vec_t v;

        //            rd wr f3      addr          sdata         rdata         lat regw br z exp_rdata     eregw ealign be       wdata
        vecs[0]  = '{1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 3, 1, 0, 0, 32'hDEADBEEF, 1, 0, 4'b0000, 32'h0};
        vecs[1]  = '{1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80112233, 1, 1, 0, 0, 32'hFFFFFF80, 1, 0, 4'b0000, 32'h0};
        vecs[2]  = '{1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80112233, 2, 1, 0, 0, 32'h00000080, 1, 0, 4'b0000, 32'h0};
        vecs[3]  = '{1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80112233, 2, 1, 0, 0, 32'hFFFF8011, 1, 0, 4'b0000, 32'h0};
        vecs[4]  = '{1, 0, 3'b101, 32'h0000_0100, 32'h0,        32'h80112233, 1, 1, 0, 0, 32'h00002233, 1, 0, 4'b0000, 32'h0};
        vecs[5]  = '{1, 0, 3'b000, 32'h0000_0101, 32'h0,        32'h80112233, 1, 1, 0, 0, 32'h00000022, 1, 0, 4'b0000, 32'h0};
        vecs[6]  = '{0, 1, 3'b001, 32'h0000_0202, 32'h0000ABCD, 32'h0,        2, 0, 0, 0, 32'h0,        0, 0, 4'b1100, 32'hABCDABCD};
        vecs[7]  = '{0, 1, 3'b000, 32'h0000_0301, 32'h000000A5, 32'h0,        1, 0, 0, 0, 32'h0,        0, 0, 4'b0010, 32'hA5A5A5A5};
        vecs[8]  = '{0, 1, 3'b010, 32'h0000_0404, 32'h12345678, 32'h0,        1, 0, 0, 0, 32'h0,        0, 0, 4'b1111, 32'h12345678};
        vecs[9]  = '{1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,        0, 1, 4'b0000, 32'h0};
        vecs[10] = '{1, 0, 3'b001, 32'h0000_0203, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,        0, 1, 4'b0000, 32'h0};
        vecs[11] = '{1, 0, 3'b011, 32'h0000_0200, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,        0, 1, 4'b0000, 32'h0};
        vecs[12] = '{0, 0, 3'b000, 32'h0000_0055, 32'h0,        32'h0,        0, 1, 1, 1, 32'h0,        1, 0, 4'b0000, 32'h0};
        vecs[13] = '{1, 1, 3'b010, 32'h0000_0408, 32'hCAFEF00D, 32'h0,        1, 0, 0, 0, 32'h0,        0, 0, 4'b1111, 32'hCAFEF00D};

        rst_n = 1'b0;
        em_valid = 1'b0; em_mem_read = 1'b0; em_mem_write = 1'b0;
        em_alu_result = 32'd0; em_store_data = 32'd0; em_funct3 = 3'd0; em_rd = 5'd0;
        em_reg_write = 1'b0; em_memtoreg = 1'b0; em_jump = 1'b0; em_pcr = 1'b0;
        em_branch = 1'b0; em_zero = 1'b0; em_pc_next = 9'd0; em_new_add = 32'd0;
        dmif.dm_ack = 1'b0; dmif.dm_rdata = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset stall", 32'(stall), 0);
        checkOutput("reset dm_req", 32'(dmif.dm_req), 0);
        checkOutput("reset wb_valid", 32'(wb_valid), 0);
        checkOutput("reset wb_read_data", wb_read_data, 0);
        checkOutput("reset dm_be", 32'(dmif.dm_be), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i + 1);

        // Access never acknowledged: four BUSY cycles with dm_req, then an aborted retirement.
        $display("[TB] timeout sequence");
        v = vecs[0];
        v.addr = 32'h0000_0500;
        driveInputs(v, 20);
        e = '{32'h0, 1'b0, 1'b0, 1'b1, 5'd20, 32'h0000_0500, 1'b0};
        exp_q.push_back(e);
        req_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (!dmif.dm_req) break;
            req_cycles++;
            if (req_cycles < 4) checkOutput("timeout stall_held", 32'(stall), 1);
            else                checkOutput("timeout stall_released", 32'(stall), 0);
        end
        em_valid = 1'b0;
        checkOutput("timeout req_cycles", 32'(req_cycles), 4);
        v = vecs[0];
        v.addr = 32'h0000_0600; v.rdata = 32'h0000CAFE; v.exp_rdata = 32'h0000CAFE; v.lat = 2;
        applyStimulus(v, 21);

        // Reset while an access is outstanding discards it without any retirement.
        $display("[TB] reset-in-busy sequence");
        v = vecs[0];
        v.addr = 32'h0000_0700;
        driveInputs(v, 22);
        @(posedge clk); #1;
        checkOutput("busy dm_req", 32'(dmif.dm_req), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst dm_req", 32'(dmif.dm_req), 0);
        checkOutput("rst stall", 32'(stall), 0);
        checkOutput("rst wb_valid", 32'(wb_valid), 0);
        em_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(vecs[12], 25);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
